// File: rtl/fpumuls_wb_if.sv
// fpumuls_wb_if: issue, multiplier result, writeback and flag signals of the fpumuls writeback stage
interface fpumuls_wb_if #(parameter int TAGW = 9);
    logic            iss_en;
    logic [TAGW-1:0] iss_tag;
    logic            iss_stall;
    logic            flush;
    logic [32:0]     mul_res;
    logic [10:0]     mul_raise;
    logic [10:0]     raise_mask;
    logic            wb_vld;
    logic            wb_rdy;
    logic [TAGW-1:0] wb_tag;
    logic [32:0]     wb_res;
    logic [10:0]     wb_flags;
    logic            wb_excpt;
    logic            sticky_clr;
    logic [10:0]     sticky;
    logic            ovf_err;
    modport master (
        output iss_en, iss_tag, flush, mul_res, mul_raise, raise_mask, wb_rdy, sticky_clr,
        input  iss_stall, wb_vld, wb_tag, wb_res, wb_flags, wb_excpt, sticky, ovf_err
    );
    modport slave (
        input  iss_en, iss_tag, flush, mul_res, mul_raise, raise_mask, wb_rdy, sticky_clr,
        output iss_stall, wb_vld, wb_tag, wb_res, wb_flags, wb_excpt, sticky, ovf_err
    );
endinterface

// File: rtl/fpumuls_wb.sv
// fpumuls_wb: tracks multiplies by tag, queues results, hands them to writeback and collects sticky flags
module fpumuls_wb #(
    parameter int LAT   = 3,
    parameter int TAGW  = 9,
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    fpumuls_wb_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [LAT-1:0]   pv;
    logic [TAGW-1:0]  pt [LAT];
    logic [TAGW+43:0] mem [DEPTH];
    logic [TAGW+43:0] head;
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    cnt, used;
    logic             acc, push, pop;
    // credits in use: valid pipe stages plus queued results
    always_comb begin
        used = cnt;
        for (int i = 0; i < LAT; i++) used = used + CW'(pv[i]);
    end
    assign bus.iss_stall = ~bus.flush & (used >= CW'(DEPTH));
    assign acc           = bus.iss_en & ~bus.iss_stall;
    assign push          = pv[LAT-1] & ~bus.flush;
    assign pop           = bus.wb_vld & bus.wb_rdy & ~bus.flush;
    assign bus.wb_vld    = cnt != '0;
    assign head          = bus.wb_vld ? mem[rp] : '0;
    assign {bus.wb_tag, bus.wb_res, bus.wb_flags} = head;
    assign bus.wb_excpt  = |(bus.wb_flags & bus.raise_mask);
    // pipe valids: stage 1 takes accepted issues (even during flush), flush empties the rest
    always_ff @(posedge clk) begin
        if (rst) pv <= '0;
        else begin
            pv[0] <= acc;
            for (int i = 1; i < LAT; i++) pv[i] <= pv[i-1] & ~bus.flush;
        end
    end
    // pipe tags travel alongside the valids
    always_ff @(posedge clk) begin
        pt[0] <= bus.iss_tag;
        for (int i = 1; i < LAT; i++) pt[i] <= pt[i-1];
    end
    // capture the multiplier output when a tracked op leaves the pipe
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {pt[LAT-1], bus.mul_res, bus.mul_raise};
    end
    // fifo pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + PW'(push);
            rp  <= rp + PW'(pop);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    // sticky flags from retired results and the issue-overflow error
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sticky  <= '0;
            bus.ovf_err <= 1'b0;
        end else begin
            bus.sticky <= (bus.sticky_clr ? '0 : bus.sticky) | (pop ? bus.wb_flags : '0);
            if (bus.iss_en & bus.iss_stall) bus.ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fpumuls_wb.sv
// tb_fpumuls_wb: scoreboard bench for fpumuls_wb with a fixed-latency multiplier mock
module tb_fpumuls_wb;
    localparam int LAT   = 3;
    localparam int TAGW  = 9;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [32:0]     res;
        logic [10:0]     flags;
    } exp_t;
    typedef struct {
        logic [TAGW-1:0] tag;
        logic [10:0]     raise;
        logic [10:0]     mask;
        logic            clr;
        logic            excpt;
        logic [10:0]     sticky;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    fpumuls_wb_if #(.TAGW(TAGW)) bus ();
    fpumuls_wb #(.LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int nchk = 0;
    int nfail = 0;
    int inflight = 0;
    int max_inflight = 0;
    int retired = 0;
    exp_t exp_q[$];
    logic [32:0] res_of [512];
    logic [10:0] flags_of [512];
    logic [TAGW-1:0] mt [LAT];
    logic [10:0] sticky_m = '0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) step();
    endtask
    task automatic issue(input logic [TAGW-1:0] t);
        bus.iss_en  = 1'b1;
        bus.iss_tag = t;
        step();
        bus.iss_en  = 1'b0;
    endtask
    task automatic wait_vld(input string nm);
        for (int n = 0; n < 20 && !bus.wb_vld; n++) step();
        chk(nm, 64'(bus.wb_vld), 64'd1);
    endtask
    task automatic drain(input string nm);
        bus.wb_rdy = 1'b1;
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) step();
        step();
        chk(nm, 64'(exp_q.size()), 64'd0);
        chk({nm, "_vld"}, 64'(bus.wb_vld), 64'd0);
    endtask
    // multiplier mock: result for the op issued LAT cycles ago
    always @(posedge clk) begin
        mt[0] <= bus.iss_tag;
        for (int i = 1; i < LAT; i++) mt[i] <= mt[i-1];
    end
    assign bus.mul_res   = res_of[mt[LAT-1]];
    assign bus.mul_raise = flags_of[mt[LAT-1]];
    // scoreboard: push accepted issues, compare retirements, model sticky flags
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        if (rst) begin
            exp_q.delete();
            sticky_m = '0;
            inflight = 0;
        end else begin
            chk("sticky", 64'(bus.sticky), 64'(sticky_m));
            if (!bus.flush && bus.wb_vld && bus.wb_rdy) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL wb_unexpected: got tag %h expected none", bus.wb_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_tag", 64'(bus.wb_tag), 64'(e.tag));
                    chk("wb_res", 64'(bus.wb_res), 64'(e.res));
                    chk("wb_flags", 64'(bus.wb_flags), 64'(e.flags));
                    chk("wb_excpt", 64'(bus.wb_excpt), 64'(|(e.flags & bus.raise_mask)));
                    sticky_m = (bus.sticky_clr ? 11'h0 : sticky_m) | e.flags;
                    inflight--;
                    retired++;
                end
            end else if (bus.sticky_clr) sticky_m = '0;
            if (bus.flush) begin
                exp_q.delete();
                inflight = 0;
            end
            if (bus.iss_en && !bus.iss_stall) begin
                n.tag   = bus.iss_tag;
                n.res   = res_of[bus.iss_tag];
                n.flags = flags_of[bus.iss_tag];
                exp_q.push_back(n);
                inflight++;
            end
            if (inflight > max_inflight) max_inflight = inflight;
        end
    end
    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
    initial begin
        vec_t tbl [6];
        logic [5:0] v;
        logic [TAGW-1:0] st;
        logic [10:0] s0;
        int t;
        int cyc;
        int nv;
        for (int i = 0; i < 512; i++) begin
            res_of[i]   = (33'(i) * 33'h1_0203) ^ 33'h1_5A5A_0000;
            flags_of[i] = '0;
        end
        tbl[0] = '{9'h021, 11'h004, 11'h004, 1'b0, 1'b1, 11'h004};
        tbl[1] = '{9'h022, 11'h010, 11'h004, 1'b1, 1'b0, 11'h010};
        tbl[2] = '{9'h023, 11'h001, 11'h7FF, 1'b0, 1'b1, 11'h011};
        tbl[3] = '{9'h024, 11'h000, 11'h7FF, 1'b0, 1'b0, 11'h011};
        tbl[4] = '{9'h025, 11'h400, 11'h000, 1'b0, 1'b0, 11'h411};
        tbl[5] = '{9'h026, 11'h002, 11'h003, 1'b1, 1'b1, 11'h002};
        bus.iss_en = 1'b0;
        bus.iss_tag = '0;
        bus.flush = 1'b0;
        bus.raise_mask = '0;
        bus.wb_rdy = 1'b0;
        bus.sticky_clr = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_vld", 64'(bus.wb_vld), 64'd0);
        chk("rst_tag", 64'(bus.wb_tag), 64'd0);
        chk("rst_res", 64'(bus.wb_res), 64'd0);
        chk("rst_flags", 64'(bus.wb_flags), 64'd0);
        chk("rst_stall", 64'(bus.iss_stall), 64'd0);
        chk("rst_ovf", 64'(bus.ovf_err), 64'd0);
        // single op: valid for one cycle, LAT+1 cycles after issue
        res_of[5] = 33'h0_40C0_0000;
        bus.wb_rdy = 1'b1;
        issue(9'h005);
        st = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            v[k] = bus.wb_vld;
            if (k == 3) st = bus.wb_tag;
        end
        step();
        chk("single_vld_pattern", 64'(v), 64'(6'b001000));
        chk("single_tag", 64'(st), 64'h05);
        // flags, trap and sticky, table driven
        bus.wb_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            flags_of[tbl[i].tag] = tbl[i].raise;
            bus.raise_mask = tbl[i].mask;
            issue(tbl[i].tag);
            wait_vld("flag_wait");
            chk("flag_tag", 64'(bus.wb_tag), 64'(tbl[i].tag));
            chk("flag_excpt", 64'(bus.wb_excpt), 64'(tbl[i].excpt));
            bus.sticky_clr = tbl[i].clr;
            bus.wb_rdy = 1'b1;
            step();
            bus.sticky_clr = 1'b0;
            bus.wb_rdy = 1'b0;
            chk("flag_sticky", 64'(bus.sticky), 64'(tbl[i].sticky));
        end
        // backpressure and credits
        bus.raise_mask = '0;
        for (int k = 1; k <= 4; k++) begin
            issue(TAGW'(k));
            chk("bp_stall", 64'(bus.iss_stall), 64'(k == 4));
        end
        issue(9'h009);
        chk("bp_ovf", 64'(bus.ovf_err), 64'd1);
        chk("bp_stall_hold", 64'(bus.iss_stall), 64'd1);
        idle(LAT + 1);
        chk("bp_stall_full", 64'(bus.iss_stall), 64'd1);
        chk("bp_head", 64'(bus.wb_tag), 64'd1);
        bus.wb_rdy = 1'b1;
        step();
        chk("bp_stall_release", 64'(bus.iss_stall), 64'd0);
        drain("bp_drain");
        // flush with two queued, one in the pipe and a new issue in the flush cycle
        flags_of[9'h011] = 11'h080;
        bus.wb_rdy = 1'b0;
        issue(9'h011);
        issue(9'h012);
        idle(2);
        issue(9'h013);
        idle(1);
        chk("flush_pre_head", 64'(bus.wb_tag), 64'h11);
        s0 = bus.sticky;
        bus.flush = 1'b1;
        bus.wb_rdy = 1'b1;
        bus.iss_en = 1'b1;
        bus.iss_tag = 9'h01F;
        step();
        bus.flush = 1'b0;
        bus.iss_en = 1'b0;
        chk("flush_empty", 64'(bus.wb_vld), 64'd0);
        wait_vld("flush_wait");
        chk("flush_tag", 64'(bus.wb_tag), 64'h1F);
        drain("flush_drain");
        chk("flush_sticky", 64'(bus.sticky), 64'(s0));
        // reset with three ops outstanding
        flags_of[9'h071] = 11'h001;
        bus.raise_mask = 11'h7FF;
        bus.wb_rdy = 1'b0;
        issue(9'h071);
        issue(9'h072);
        issue(9'h073);
        idle(1);
        chk("rst_mid_pre_excpt", 64'(bus.wb_excpt), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_vld", 64'(bus.wb_vld), 64'd0);
        chk("rst_mid_tag", 64'(bus.wb_tag), 64'd0);
        chk("rst_mid_res", 64'(bus.wb_res), 64'd0);
        chk("rst_mid_flags", 64'(bus.wb_flags), 64'd0);
        chk("rst_mid_excpt", 64'(bus.wb_excpt), 64'd0);
        chk("rst_mid_stall", 64'(bus.iss_stall), 64'd0);
        chk("rst_mid_sticky", 64'(bus.sticky), 64'd0);
        chk("rst_mid_ovf", 64'(bus.ovf_err), 64'd0);
        bus.wb_rdy = 1'b1;
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            nv += int'(bus.wb_vld);
            step();
        end
        chk("rst_no_stale", 64'(nv), 64'd0);
        // streaming with random writeback readiness
        bus.raise_mask = '0;
        max_inflight = 0;
        retired = 0;
        t = 0;
        cyc = 0;
        while (t < 100 && cyc < 2000) begin
            bus.wb_rdy = 1'($urandom_range(0, 1));
            if (bus.iss_stall) bus.iss_en = 1'b0;
            else begin
                bus.iss_en = 1'b1;
                bus.iss_tag = TAGW'(256 + t);
                t++;
            end
            step();
            cyc++;
        end
        bus.iss_en = 1'b0;
        chk("stream_issued", 64'(t), 64'd100);
        drain("stream_drain");
        chk("stream_retired", 64'(retired), 64'd100);
        chk("stream_ovf", 64'(bus.ovf_err), 64'd0);
        chk("stream_max_used", 64'(max_inflight <= DEPTH), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
